ic_7483: RTL and testbench
==========================

IC_7483 -- requirements
Module: ic_7483

Interface
REQ-001 Parameter REG_OUT, default 1: 1 = registered outputs (1-cycle latency); 0 = purely combinational outputs, with clk/rst ignored.
REQ-002 clk  input  1  clock; the block uses one clock; sum/cout update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 sum  output  4  4-bit sum of a + b + cin.
REQ-005 cout  output  1  carry out of bit 3.
REQ-006 a  input  4  addend A.
REQ-007 b  input  4  addend B.
REQ-008 cin  input  1  carry in to bit 0.
REQ-009 Port declaration order SHALL be sum, cout, a, b, cin, clk, rst, so that positional instances using the first five ports stay valid when REG_OUT=0.

Function
REQ-010 The block SHALL compute {cout, sum} = a + b + cin as a 5-bit result, zero-extended, with no overflow loss.
REQ-011 The block SHALL form per-bit generate g[i] = a[i]&b[i] and propagate p[i] = a[i]^b[i] for i = 0..3.
REQ-012 The block SHALL derive carries c1..c4 by full carry-lookahead from g, p and cin, not by a ripple chain (7483-style internal lookahead); c4 is cout.
REQ-013 The block SHALL compute sum[i] = p[i] ^ c[i], with c0 = cin.
REQ-014 With REG_OUT=0, sum/cout SHALL follow the inputs combinationally with zero cycle latency.
REQ-015 With REG_OUT=1, sum/cout SHALL be registered, presenting the result of inputs sampled at rising edge N from that edge onward (latency 1 cycle); inputs are sampled every cycle, with no enable and no handshake.
REQ-016 Maximum result case: a=4'hF, b=4'hF, cin=1 SHALL give sum=4'hF, cout=1.
REQ-017 Wrap-around: any result >= 16 SHALL set cout=1, with sum holding the low 4 bits of the result.
REQ-018 X/Z on any input bit SHALL NOT be masked; the output propagates X per standard operator semantics.
REQ-019 The block SHALL contain no internal state other than the optional output registers.

Reset
REQ-020 With REG_OUT=1, rst=1 SHALL immediately (asynchronously, without waiting for clk) force sum=4'h0 and cout=0.
REQ-021 While rst=1 the outputs SHALL hold 0 regardless of clk and the inputs.
REQ-022 On rst deassertion, the first rising clk edge with rst=0 SHALL load the current a+b+cin result.
REQ-023 Reset asserted mid-operation SHALL discard the pending result; no stale value reappears after release.
REQ-024 With REG_OUT=0, rst SHALL have no effect on the outputs.

Verification
REQ-025 a=4'hF, b=4'h4, cin=0 -> sum=4'h3, cout=1.
REQ-026 a=4'h4, b=4'h7, cin=0 -> sum=4'hB, cout=0.
REQ-027 a=4'h8, b=4'h4, cin=1 -> sum=4'hD, cout=0.
REQ-028 a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1 (wrap); a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1.
REQ-029 The bench SHALL run an exhaustive sweep of all 512 {a, b, cin} combinations in both REG_OUT settings and compare against the 5-bit reference sum (REG_OUT=1 checked one cycle later).
REQ-030 REG_OUT=1 reset test: the bench SHALL load a=4'hF, b=4'hF, cin=1 and clock once (expect sum=4'hF, cout=1), then assert rst between edges (expect immediate sum=0, cout=0), then release rst and clock once (expect sum=4'hF, cout=1).

Source files
------------

// File: rtl/ic_7483.sv
// rtl/ic_7483.sv - 4-bit carry-lookahead adder with optional registered outputs
module ic_7483 #(
    parameter int REG_OUT = 1
) (
    output logic [3:0] sum,
    output logic       cout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       clk,
    input  logic       rst
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum_c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum-of-products of g, p and cin; no carry feeds another.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum_c = p ^ c[3:0];

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [3:0] sum_q;
            logic       cout_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q  <= 4'h0;
                    cout_q <= 1'b0;
                end else begin
                    sum_q  <= sum_c;
                    cout_q <= c[4];
                end
            end

            assign sum  = sum_q;
            assign cout = cout_q;
        end else begin : g_comb
            // clk and rst are kept only so the port list is the same in both builds.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign sum  = sum_c;
            assign cout = c[4];
        end
    endgenerate

endmodule

// File: tb/tb_ic_7483.sv
// tb/tb_ic_7483.sv - scoreboard bench for ic_7483 in registered and combinational builds
module tb_ic_7483;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a   = 4'h0;
    logic [3:0] b   = 4'h0;
    logic       cin = 1'b0;

    logic [3:0] sum_r, sum_c;
    logic       cout_r, cout_c;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] exp;
    } item_t;

    item_t q_reg[$];
    item_t q_comb[$];

    always #5 clk = ~clk;

    ic_7483 #(.REG_OUT(1)) u_reg (
        .sum(sum_r), .cout(cout_r), .a(a), .b(b), .cin(cin), .clk(clk), .rst(rst)
    );

    ic_7483 #(.REG_OUT(0)) u_comb (
        .sum(sum_c), .cout(cout_c), .a(a), .b(b), .cin(cin), .clk(clk), .rst(rst)
    );

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {cout,sum}=%h required %h", name, act, exp);
    endtask

    task automatic issue(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                         input logic [4:0] exp);
        item_t it;
        @(posedge clk);
        #2;
        a   = va;
        b   = vb;
        cin = vc;
        it  = '{a: va, b: vb, cin: vc, exp: exp};
        q_reg.push_back(it);
        q_comb.push_back(it);
    endtask

    // Registered build: a result issued after edge N is presented from edge N+1.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (q_reg.size() != 0) begin
                it = q_reg.pop_front();
                check($sformatf("reg a=%h b=%h cin=%b", it.a, it.b, it.cin),
                      {cout_r, sum_r}, it.exp);
            end
        end
    end

    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #1;
            if (q_comb.size() != 0) begin
                it = q_comb.pop_front();
                check($sformatf("comb a=%h b=%h cin=%b", it.a, it.b, it.cin),
                      {cout_c, sum_c}, it.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1);
    end

    localparam int N_DIR = 5;
    logic [13:0] dir_tab [N_DIR] = '{
        {4'hF, 4'h4, 1'b0, 5'h13},
        {4'h4, 4'h7, 1'b0, 5'h0B},
        {4'h8, 4'h4, 1'b1, 5'h0D},
        {4'hF, 4'h1, 1'b0, 5'h10},
        {4'hF, 4'hF, 1'b1, 5'h1F}
    };

    initial begin
        logic [13:0] v;
        logic [4:0]  ref_sum;
        int          wait_cyc;

        // Reset state, asserted before any clock edge.
        a = 4'h9; b = 4'h8; cin = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("reset_async", {cout_r, sum_r}, 5'h00);
        check("comb_ignores_rst", {cout_c, sum_c}, 5'h12);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", {cout_r, sum_r}, 5'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N_DIR; i++) begin
            v = dir_tab[i];
            issue(v[13:10], v[9:6], v[5], v[4:0]);
        end

        for (int k = 0; k < 512; k++) begin
            ref_sum = {1'b0, k[8:5]} + {1'b0, k[4:1]} + {4'h0, k[0]};
            issue(k[8:5], k[4:1], k[0], ref_sum);
        end

        wait_cyc = 0;
        while ((q_reg.size() != 0 || q_comb.size() != 0) && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        n_total++;
        if (q_reg.size() == 0 && q_comb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d pending required 0/0", q_reg.size(), q_comb.size());

        // Reset sequence on the registered build, directed.
        @(posedge clk);
        #2;
        a = 4'hF; b = 4'hF; cin = 1'b1;
        @(posedge clk);
        #1;
        check("rst_seq_load", {cout_r, sum_r}, 5'h1F);
        #2 rst = 1'b1;
        #1;
        check("rst_seq_async_clear", {cout_r, sum_r}, 5'h00);
        a = 4'h1; b = 4'h1; cin = 1'b0;
        @(posedge clk);
        #1;
        check("rst_seq_hold_over_edge", {cout_r, sum_r}, 5'h00);
        a = 4'hF; b = 4'hF; cin = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_seq_no_stale", {cout_r, sum_r}, 5'h00);
        @(posedge clk);
        #1;
        check("rst_seq_first_edge", {cout_r, sum_r}, 5'h1F);
        #1;
        a = 4'h2; b = 4'h3; cin = 1'b0;
        @(posedge clk);
        #1;
        check("rst_seq_resume", {cout_r, sum_r}, 5'h05);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
